sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Sits directly upstream of the SDRAM controller.
- Multiplexes up to 15 bus masters (CPU I/D caches, blitter, video fetch) onto the controller's single request port.
- Arbitrates round-robin, holds the granted request stable until the controller accepts it, and demultiplexes the controller's tagged read-data/valid/complete pulses back to the issuing master.

Parameters:
- NUM_MASTERS, 4, number of master ports (1..15). Master index i is tagged on the controller port as ID i+1; ID 0 means "none".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_request  in  NUM_MASTERS  per-master request; held high until m_ack
- m_write  in  NUM_MASTERS  per-master write flag
- m_address  in  26*NUM_MASTERS  per-master byte address; slice i = [26i+25:26i]
- m_wdata  in  32*NUM_MASTERS  per-master write data
- m_byte_en  in  4*NUM_MASTERS  per-master byte enables
- m_burst  in  NUM_MASTERS  per-master 32-byte burst read flag
- m_ack  out  NUM_MASTERS  one-cycle pulse: request accepted by controller
- m_rvalid  out  NUM_MASTERS  one-cycle pulse per returned 32-bit read word
- m_complete  out  NUM_MASTERS  one-cycle pulse: read transaction finished
- m_rdata  out  32  read data, shared by all masters; qualified by m_rvalid
- sdram_request  out  1  registered; held high while a transaction is offered
- sdram_master  out  4  registered; ID of the offered transaction
- sdram_write, sdram_address[26], sdram_wdata[32], sdram_byte_en[4], sdram_burst  out  registered copy of the granted master's fields
- sdram_ready  in  1  controller accepts the offered transaction this cycle (combinational on the controller side)
- sdram_rdata  in  32; sdram_valid  in  4; sdram_complete  in  4  tagged returns from the controller

Behaviour:
- Reset values:
  - sdram_request=0, sdram_master=0, all sdram_* data outputs=0.
  - m_ack=0, m_rvalid=0, m_complete=0.
  - Round-robin pointer last_grant=NUM_MASTERS-1, so master 0 has first priority after reset.
  - State=ARB_IDLE.
- State ARB_IDLE:
  - If any m_request is set, select the first requesting index searching last_grant+1, last_grant+2, …, wrapping modulo NUM_MASTERS.
  - Latch that master's write/address/wdata/byte_en/burst into the sdram_* registers, set sdram_master=i+1 and sdram_request=1, update last_grant=i, and go to ARB_OFFER.
  - Otherwise stay in ARB_IDLE with sdram_request=0.
- State ARB_OFFER:
  - Acceptance is defined as sdram_request && sdram_ready in the same cycle.
  - On acceptance: m_ack[last_grant]=1 combinationally in that cycle; sdram_request<=0; sdram_master<=0; go to ARB_IDLE.
  - Without acceptance: all sdram_* outputs hold stable. There is no timeout.
  - Minimum grant-to-grant spacing is 2 cycles: offer, then idle/reselect.
  - sdram_ready while sdram_request=0 is ignored.
- Sampling rule: master fields are sampled only in the ARB_IDLE grant cycle. A master that changes fields before m_ack has undefined results. A master that deasserts m_request before m_ack violates protocol; the arbiter still completes the offer.
- Read return path:
  - m_rdata = sdram_rdata (pass-through).
  - m_rvalid[i] = (sdram_valid == i+1).
  - m_complete[i] = (sdram_complete == i+1).
  - Both are purely combinational, with zero added latency.
  - Tag 0 or tag > NUM_MASTERS produces no pulse.
- Returns are independent of arbitration state. A read return for master A may overlap an offer for master B.
- Writes receive only m_ack, never m_complete.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 grants.
- Reset asserted mid-offer: sdram_request drops at the next edge and the in-flight offer is discarded (no m_ack).

Optional Feature:
- Macro SDRAM_ARB_PRIORITY_EN.
- Defined: master 0 (video fetch) is fixed highest priority; it wins any ARB_IDLE selection in which it requests, and last_grant is not updated when master 0 wins. Masters 1..N-1 round-robin among themselves.
- Undefined: pure round-robin across all masters as above.

Decomposition:
- Shared package sdram_pkg:
  - constants SDRAM_ADDR_W=26, SDRAM_DATA_W=32, SDRAM_BE_W=4, SDRAM_ID_W=4, SDRAM_ID_NONE=0
  - arbiter state encoding ARB_IDLE/ARB_OFFER
- One natural sub-module, rr_select: combinational round-robin priority picker taking request vector and last_grant, returning found flag and index.

Test Plan:
- Single master 1 read, addr 0x0000100, burst=0, sdram_ready high on the offer cycle:
  - sdram_request rises 1 cycle after m_request.
  - sdram_master=2; m_ack[1] pulses once.
  - Later sdram_valid=2 with rdata 0xDEADBEEF yields m_rvalid[1]=1 and m_rdata=0xDEADBEEF.
- All 4 masters request continuously with ready always high: grant order 0,1,2,3,0,1…, with a new m_ack every 2 cycles.
- Stall case: master 2 write addr 0x3FFFFFC, wdata 0x12345678, byte_en 0xC, ready held low 10 cycles:
  - sdram_* outputs stay constant throughout.
  - m_ack[2] pulses exactly on the cycle ready goes high.
- Burst return: sdram_valid=3 for 8 beats, then sdram_complete=3 → m_rvalid[2] pulses 8 times, m_complete[2] once; no pulses on other masters.
- Reset is asserted during ARB_OFFER → sdram_request=0 next cycle, no m_ack; the first grant after reset goes to master 0.
- With SDRAM_ARB_PRIORITY_EN, masters 0 and 1 request continuously → master 0 wins every grant; master 1 is granted only after master 0 deasserts.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared constants and arbiter state encoding for the SDRAM front-end.
// Controller-side master IDs are 1-based; ID 0 means no master.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 26;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_BE_W   = 4;
  localparam int SDRAM_ID_W   = 4;

  localparam logic [SDRAM_ID_W-1:0] SDRAM_ID_NONE = '0;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// Round-robin picker: returns the first requester strictly after i_last_grant,
// wrapping to the lowest requester when none sits above it.
module rr_select
  import sdram_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            i_req,
  input  logic [SDRAM_ID_W-1:0]   i_last_grant,
  output logic                    o_found,
  output logic [SDRAM_ID_W-1:0]   o_idx
);

  logic                  w_hi_found;
  logic [SDRAM_ID_W-1:0] w_hi_idx;
  logic                  w_lo_found;
  logic [SDRAM_ID_W-1:0] w_lo_idx;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = SDRAM_ID_W'(i);
        if (SDRAM_ID_W'(i) > i_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SDRAM_ID_W'(i);
        end
      end
    end
  end

  assign o_found = w_lo_found;
  assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin multiplexer of bus masters onto the SDRAM controller request port,
// with tag-based demux of read returns. SDRAM_ARB_PRIORITY_EN makes master 0 fixed-highest.
//
// state     | meaning
// ARB_IDLE  | no offer outstanding; pick next requester
// ARB_OFFER | sdram_* presented and held until sdram_ready
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_MASTERS-1:0]              m_request,
  input  logic [NUM_MASTERS-1:0]              m_write,
  input  logic [SDRAM_ADDR_W*NUM_MASTERS-1:0] m_address,
  input  logic [SDRAM_DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [SDRAM_BE_W*NUM_MASTERS-1:0]   m_byte_en,
  input  logic [NUM_MASTERS-1:0]              m_burst,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  output logic [NUM_MASTERS-1:0]              m_complete,
  output logic [SDRAM_DATA_W-1:0]             m_rdata,
  output logic                                sdram_request,
  output logic [SDRAM_ID_W-1:0]               sdram_master,
  output logic                                sdram_write,
  output logic [SDRAM_ADDR_W-1:0]             sdram_address,
  output logic [SDRAM_DATA_W-1:0]             sdram_wdata,
  output logic [SDRAM_BE_W-1:0]               sdram_byte_en,
  output logic                                sdram_burst,
  input  logic                                sdram_ready,
  input  logic [SDRAM_DATA_W-1:0]             sdram_rdata,
  input  logic [SDRAM_ID_W-1:0]               sdram_valid,
  input  logic [SDRAM_ID_W-1:0]               sdram_complete
);

  localparam logic [SDRAM_ID_W-1:0] LAST_INIT = SDRAM_ID_W'(NUM_MASTERS - 1);

  arb_state_t              r_state;
  logic [SDRAM_ID_W-1:0]   r_last_grant;

  logic [NUM_MASTERS-1:0]  w_rr_req;
  logic                    w_rr_found;
  logic [SDRAM_ID_W-1:0]   w_rr_idx;
  logic                    w_found;
  logic [SDRAM_ID_W-1:0]   w_idx;
  logic                    w_update_last;
  logic                    w_accept;

  logic                    w_sel_write;
  logic [SDRAM_ADDR_W-1:0] w_sel_addr;
  logic [SDRAM_DATA_W-1:0] w_sel_wdata;
  logic [SDRAM_BE_W-1:0]   w_sel_be;
  logic                    w_sel_burst;

`ifdef SDRAM_ARB_PRIORITY_EN
  // Master 0 bypasses the rotation and leaves the pointer untouched.
  always_comb begin
    w_rr_req      = m_request;
    w_rr_req[0]   = 1'b0;
    w_found       = m_request[0] | w_rr_found;
    w_idx         = m_request[0] ? SDRAM_ID_W'(0) : w_rr_idx;
    w_update_last = ~m_request[0];
  end
`else
  always_comb begin
    w_rr_req      = m_request;
    w_found       = w_rr_found;
    w_idx         = w_rr_idx;
    w_update_last = 1'b1;
  end
`endif

  rr_select #(.N(NUM_MASTERS)) u_rr_select (
    .i_req        (w_rr_req),
    .i_last_grant (r_last_grant),
    .o_found      (w_rr_found),
    .o_idx        (w_rr_idx)
  );

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_burst = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_idx == SDRAM_ID_W'(i)) begin
        w_sel_write = m_write[i];
        w_sel_addr  = m_address[i*SDRAM_ADDR_W +: SDRAM_ADDR_W];
        w_sel_wdata = m_wdata[i*SDRAM_DATA_W +: SDRAM_DATA_W];
        w_sel_be    = m_byte_en[i*SDRAM_BE_W +: SDRAM_BE_W];
        w_sel_burst = m_burst[i];
      end
    end
  end

  // A cycle with reset high never acknowledges; the offer is simply dropped.
  assign w_accept = (r_state == ARB_OFFER) && sdram_request && sdram_ready && !reset;

  always_comb begin
    m_ack      = '0;
    m_rvalid   = '0;
    m_complete = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ack[i]      = w_accept && (sdram_master == SDRAM_ID_W'(i + 1));
      m_rvalid[i]   = (sdram_valid == SDRAM_ID_W'(i + 1));
      m_complete[i] = (sdram_complete == SDRAM_ID_W'(i + 1));
    end
  end

  assign m_rdata = sdram_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ARB_IDLE;
      r_last_grant  <= LAST_INIT;
      sdram_request <= 1'b0;
      sdram_master  <= SDRAM_ID_NONE;
      sdram_write   <= 1'b0;
      sdram_address <= '0;
      sdram_wdata   <= '0;
      sdram_byte_en <= '0;
      sdram_burst   <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            sdram_write   <= w_sel_write;
            sdram_address <= w_sel_addr;
            sdram_wdata   <= w_sel_wdata;
            sdram_byte_en <= w_sel_be;
            sdram_burst   <= w_sel_burst;
            sdram_master  <= w_idx + SDRAM_ID_W'(1);
            sdram_request <= 1'b1;
            if (w_update_last) r_last_grant <= w_idx;
            r_state       <= ARB_OFFER;
          end
        end
        ARB_OFFER: begin
          if (w_accept) begin
            sdram_request <= 1'b0;
            sdram_master  <= SDRAM_ID_NONE;
            r_state       <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
